mdio_master: RTL
================

Name: mdio_master

Overview:
- IEEE 802.3 Clause 22 MDIO management initiator.
- Generates MDC and drives or releases MDIO towards the external PHY, which is the management responder.
- Sits beside the MII MAC in the 125 MHz core clock domain; the top level maps mdio_o/mdio_t/mdio_i onto an IOBUF on the PHY MDIO pin.
- Issues single register reads and writes from a valid/ready command port and returns the result on a one-cycle response strobe.

Parameters:
MDC_DIV, 25, clk cycles per MDC half-period (MDC = Fclk/(2*MDC_DIV); 2.5 MHz at 125 MHz); legal range 1..255
PREAMBLE_EN, 1, 1 = send 32-bit all-ones preamble before each frame; 0 = suppressed preamble

Ports:
clk  input  1  core clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  block idle, command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write (OP=01), 0 = read (OP=10)
cmd_phy_addr  input  5  PHYAD
cmd_reg_addr  input  5  REGAD
cmd_wdata  input  16  write data (ignored on read)
rsp_valid  output  1  one-cycle pulse at frame end
rsp_rdata  output  16  read data; 0x0000 for writes; held until next rsp_valid
rsp_ta_err  output  1  read only: PHY failed to drive TA bit 2 low; held with rsp_rdata
busy  output  1  frame in progress (inverse of cmd_ready)
mdc_o  output  1  management clock to PHY
mdio_o  output  1  MDIO drive value
mdio_t  output  1  MDIO tristate: 1 = released (high-Z), 0 = driven
mdio_i  input  1  MDIO pin value; asynchronous, double-flop synchronised internally

Behaviour:
- Reset (async assert, sync release): mdc_o=0, mdio_o=1, mdio_t=1, cmd_ready=1, busy=0, rsp_valid=0, rsp_rdata=0, rsp_ta_err=0, state=IDLE, synchroniser flops=1.
- Command capture: all cmd_* fields are latched on acceptance. cmd_ready drops the next cycle. cmd_valid while busy is ignored and must not corrupt the frame.
- Frame bit order, MSB first:
  - [preamble 32x'1' if PREAMBLE_EN]
  - ST=01
  - OP (01 write / 10 read)
  - PHYAD[4:0]
  - REGAD[4:0]
  - TA
  - DATA[15:0]
- Frame length N = 64 bits, or 32 bits when PREAMBLE_EN=0.
- States:
  - IDLE: mdc_o=0, mdio_t=1.
  - SHIFT: bit-serial transfer.
  - DONE: one cycle, asserts rsp_valid, then returns to IDLE.
- Bit timing: each bit is a low phase of MDC_DIV clks followed by a high phase of MDC_DIV clks.
  - A new bit is presented on mdio_o in the first cycle of the low phase, i.e. coincident with the MDC falling edge, or with the first cycle of SHIFT for bit 0.
  - mdc_o rises after MDC_DIV clks, so MDIO setup before rising MDC is MDC_DIV clk periods.
- Write frame: mdio_t=0 for all N bits; TA is driven as '1','0'.
- Read frame:
  - mdio_t=0 through REGAD.
  - mdio_t=1 from the first TA bit through DATA[0]; mdio_o=1 while released.
- Read sampling:
  - The synchronised mdio_i is sampled in the last clk of each high phase for TA bit 2 and all 16 data bits.
  - rsp_ta_err = sampled TA bit 2 != 0.
  - Data is shifted into rsp_rdata MSB first. rsp_rdata is loaded regardless of ta_err, so an absent PHY gives 0xFFFF through the pull-up.
- Frame end: after the high phase of the final bit:
  - mdc_o=0, mdio_t=1, mdio_o=1.
  - DONE asserts rsp_valid for exactly 1 clk.
  - cmd_ready=1 the following cycle.
- Latency: acceptance to rsp_valid = 1 + N*2*MDC_DIV clks. A back-to-back command accepted at the first cycle of ready starts with MDC low, with no extra idle MDC.
- Counters: half-period counter 8 bits, wraps at MDC_DIV-1; bit counter 6 bits, counts 0..N-1. No other wrap cases.
- Reset mid-frame: immediate abort, all outputs to reset values, no rsp_valid. The next accepted command starts a fresh frame.
- mdc_o and mdio_o/mdio_t are registered outputs, glitch-free.

Test Plan:
- MDC_DIV=2, PREAMBLE_EN=1; write phy=0x01, reg=0x00, data=0x1140:
  - Serial stream is 32x'1', 01 01 00001 00000 10 0001000101000000.
  - mdc period is 4 clks; mdio_t=0 throughout.
  - rsp_valid 257 clks after acceptance, with rsp_rdata=0x0000.
- MDC_DIV=2; read phy=0x03, reg=0x02; PHY model drives TA '0' then 0x796D on MDC rising edges:
  - Header bits are 01 10 00011 00010.
  - mdio_t=1 from TA onward.
  - rsp_rdata=0x796D, rsp_ta_err=0.
- Read with no PHY (mdio_i held 1) -> rsp_rdata=0xFFFF, rsp_ta_err=1.
- Hold cmd_valid high with changing fields during busy -> only the first command is transmitted; the next is accepted the cycle after rsp_valid.
- Assert rst_n=0 at bit 40 of a write -> mdc_o=0, mdio_t=1 asynchronously; no rsp_valid; a following read completes correctly.
- PREAMBLE_EN=0, MDC_DIV=1 read -> frame is 32 bits, rsp_valid 65 clks after acceptance.

Source files
------------

// File: rtl/mdio_master.sv
// mdio_master: Clause 22 MDIO initiator issuing single register reads/writes from a valid/ready port
module mdio_master #(
  parameter int MDC_DIV     = 25,
  parameter bit PREAMBLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_ta_err,
  output logic        busy,
  output logic        mdc_o,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);
  localparam int         N    = PREAMBLE_EN ? 64 : 32;
  localparam logic [7:0] HMAX = 8'(MDC_DIV - 1);
  localparam logic [5:0] BMAX = 6'(N - 1);
  localparam logic [5:0] TA1  = 6'(N - 18);
  localparam logic [5:0] TA2  = 6'(N - 17);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_n;
  logic [7:0]  hcnt;
  logic [5:0]  bcnt;
  logic        phase;
  logic [63:0] shreg;
  logic        rd;
  logic [14:0] rx;
  logic        ta;
  logic        s1, s2;
  logic        accept, half_end, bit_end, frame_end, sample;
  logic [31:0] frame32;
  logic [63:0] frame;

  // Released read bits (TA and DATA) are loaded as ones so mdio_o idles high while mdio_t=1
  assign frame32 = {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy_addr, cmd_reg_addr,
                    cmd_write ? {2'b10, cmd_wdata} : 18'h3ffff};
  assign frame   = PREAMBLE_EN ? {32'hffff_ffff, frame32} : {frame32, 32'h0};

  assign cmd_ready = state == IDLE;
  assign busy      = !cmd_ready;
  assign rsp_valid = state == DONE;

  // Phase/bit boundary decode and next-state selection
  always_comb begin
    accept    = state == IDLE && cmd_valid;
    half_end  = state == SHIFT && hcnt == HMAX;
    bit_end   = half_end && phase;
    frame_end = bit_end && bcnt == BMAX;
    sample    = bit_end && rd && bcnt >= TA2;
    state_n   = state == DONE ? IDLE : accept ? SHIFT : frame_end ? DONE : state;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;

  // Two-flop synchroniser for the asynchronous MDIO pin, idling at the pull-up level
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s2, s1} <= 2'b11;
    else {s2, s1} <= {s1, mdio_i};

  // MDC generation, bit serialisation, read sampling and response capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hcnt       <= '0;
      bcnt       <= '0;
      phase      <= 1'b0;
      shreg      <= '0;
      rd         <= 1'b0;
      rx         <= '0;
      ta         <= 1'b0;
      mdc_o      <= 1'b0;
      mdio_o     <= 1'b1;
      mdio_t     <= 1'b1;
      rsp_rdata  <= '0;
      rsp_ta_err <= 1'b0;
    end else if (accept) begin
      hcnt   <= '0;
      bcnt   <= '0;
      phase  <= 1'b0;
      rd     <= !cmd_write;
      mdc_o  <= 1'b0;
      mdio_o <= frame[63];
      mdio_t <= 1'b0;
      shreg  <= {frame[62:0], 1'b0};
    end else if (state == SHIFT) begin
      hcnt <= half_end ? '0 : hcnt + 8'd1;
      if (half_end) phase <= !phase;
      if (half_end && !phase) mdc_o <= 1'b1;
      if (sample && bcnt == TA2) ta <= s2;
      if (sample && bcnt != TA2) rx <= {rx[13:0], s2};
      if (frame_end) begin
        mdc_o      <= 1'b0;
        mdio_o     <= 1'b1;
        mdio_t     <= 1'b1;
        rsp_rdata  <= rd ? {rx, s2} : 16'h0;
        rsp_ta_err <= rd && ta;
      end else if (bit_end) begin
        mdc_o  <= 1'b0;
        bcnt   <= bcnt + 6'd1;
        mdio_o <= shreg[63];
        shreg  <= {shreg[62:0], 1'b0};
        mdio_t <= rd && (bcnt + 6'd1 >= TA1);
      end
    end
endmodule
